// File: rtl/glitcbus_pkg.sv
// Shared types and constants for the GLITC-side GLITCbus target.
package glitcbus_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 7;
    localparam int RDWR_BIT       = 7;
    localparam int RD_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RREQ,
        RWAIT,
        RDATA,
        TURN,
        DONE
    } state_t;

endpackage

// File: rtl/glitcbus_ilogic.sv
// Input capture flops for the bus pins; isolated so they can pack into IOB input registers.
module glitcbus_ilogic (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       SEL_I,
    input  logic [7:0] AD_I,
    output logic       sel_q,
    output logic [7:0] ad_q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel_q <= 1'b0;
            ad_q  <= 8'h00;
        end else begin
            sel_q <= SEL_I;
            ad_q  <= AD_I;
        end
    end

endmodule

// File: rtl/glitcbus_slave.sv
// GLITCbus target: decodes address phase, assembles 32-bit writes into register strobes,
// fetches 32-bit reads from the register file and returns them LSB-first on the AD lines.
module glitcbus_slave
    import glitcbus_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int ADDR_W     = glitcbus_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              BUS_SEL_I,
    input  logic [7:0]        BUS_AD_I,
    output logic [7:0]        BUS_AD_O,
    output logic              BUS_AD_T,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [31:0]       REG_DAT_O,
    output logic              REG_WR,
    output logic              REG_RD,
    input  logic [31:0]       REG_DAT_I
);

    logic        sel_q;
    logic [7:0]  ad_q;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] rd_hi;
    logic        ld_addr, shift_w, cap_rd, shift_r, wr_d, rd_d, t_d;

    glitcbus_ilogic u_ilogic (
        .CLK   (CLK),
        .nRST  (nRST),
        .SEL_I (BUS_SEL_I),
        .AD_I  (BUS_AD_I),
        .sel_q (sel_q),
        .ad_q  (ad_q)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every state except TURN/DONE needs SEL held; losing it returns straight to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_addr = 1'b0;
        shift_w = 1'b0;
        cap_rd  = 1'b0;
        shift_r = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        t_d     = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (sel_q) begin
                    ld_addr = 1'b1;
                    cnt_d   = 3'd0;
                    if (ad_q[RDWR_BIT]) begin
                        state_d = RREQ;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (!sel_q) begin
                    state_d = IDLE;
                end else begin
                    shift_w = 1'b1;
                    if (cnt_q == 3'(BYTES_PER_WORD - 1)) begin
                        state_d = DONE;
                        wr_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            RREQ: begin
                if (!sel_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RWAIT;
                    cnt_d   = 3'd0;
                end
            end
            RWAIT: begin
                if (!sel_q) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'(RD_LATENCY - 1)) begin
                    state_d = RDATA;
                    cap_rd  = 1'b1;
                    t_d     = 1'b0;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RDATA: begin
                if (!sel_q) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'(BYTES_PER_WORD - 1)) begin
                    state_d = TURN;
                end else begin
                    t_d     = 1'b0;
                    shift_r = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            TURN: state_d = DONE;
            DONE: begin
                if (!sel_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // {rd_hi, BUS_AD_O} together form the 32-bit read shift register; the low byte is the pin flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            BUS_AD_O  <= 8'h00;
            BUS_AD_T  <= 1'b1;
            REG_ADDR  <= '0;
            REG_DAT_O <= 32'h0;
            REG_WR    <= 1'b0;
            REG_RD    <= 1'b0;
            rd_hi     <= 24'h0;
        end else begin
            REG_WR   <= wr_d;
            REG_RD   <= rd_d;
            BUS_AD_T <= t_d;
            if (ld_addr) REG_ADDR <= ad_q[ADDR_W-1:0];
            if (shift_w) REG_DAT_O <= {ad_q, REG_DAT_O[31:8]};
            if (cap_rd) begin
                rd_hi    <= REG_DAT_I[31:8];
                BUS_AD_O <= REG_DAT_I[7:0];
            end else if (shift_r) begin
                rd_hi    <= {8'h00, rd_hi[23:8]};
                BUS_AD_O <= rd_hi[7:0];
            end
        end
    end

endmodule

// File: tb/tb_glitcbus_slave.sv
// Bench for glitcbus_slave: two instances (read latency 2 and 5) share the bus pins and are
// checked cycle by cycle against a timeline model derived from the transaction rules.
module tb_glitcbus_slave;

    localparam int LAT_A = 2;
    localparam int LAT_B = 5;

    typedef struct {
        bit          rdwr;
        logic [6:0]  addr;
        logic [31:0] data;
        int          hold;
        int          exp_wr;
        int          exp_bytes_a;
        int          exp_bytes_b;
    } vec_t;

    logic        clk  = 1'b0;
    logic        nrst = 1'b1;
    logic        sel  = 1'b0;
    logic [7:0]  ad   = 8'h00;

    logic [7:0]  ad_o_a, ad_o_b;
    logic        ad_t_a, ad_t_b;
    logic [6:0]  addr_a, addr_b;
    logic [31:0] dat_o_a, dat_o_b;
    logic        wr_a, wr_b, rd_a, rd_b;
    logic [31:0] dat_i_a = 32'h0;
    logic [31:0] dat_i_b = 32'h0;

    logic [31:0] rf [128];
    logic [7:0]  pipe_a, pipe_b;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt [2];
    int byte_cnt [2];

    always #5 clk = ~clk;

    glitcbus_slave #(.RD_LATENCY(LAT_A)) dut_a (
        .CLK(clk), .nRST(nrst), .BUS_SEL_I(sel), .BUS_AD_I(ad),
        .BUS_AD_O(ad_o_a), .BUS_AD_T(ad_t_a), .REG_ADDR(addr_a), .REG_DAT_O(dat_o_a),
        .REG_WR(wr_a), .REG_RD(rd_a), .REG_DAT_I(dat_i_a)
    );

    glitcbus_slave #(.RD_LATENCY(LAT_B)) dut_b (
        .CLK(clk), .nRST(nrst), .BUS_SEL_I(sel), .BUS_AD_I(ad),
        .BUS_AD_O(ad_o_b), .BUS_AD_T(ad_t_b), .REG_ADDR(addr_b), .REG_DAT_O(dat_o_b),
        .REG_WR(wr_b), .REG_RD(rd_b), .REG_DAT_I(dat_i_b)
    );

    // Register-file responders: data is correct only in the cycle it is promised, inverted otherwise.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) pipe_a <= 8'h00;
        else       pipe_a <= {pipe_a[6:0], rd_a};
    end
    always @(posedge clk or negedge nrst) begin
        if (!nrst) pipe_b <= 8'h00;
        else       pipe_b <= {pipe_b[6:0], rd_b};
    end
    always @(negedge clk) dat_i_a = pipe_a[LAT_A-1] ? rf[addr_a] : ~rf[addr_a];
    always @(negedge clk) dat_i_b = pipe_b[LAT_B-1] ? rf[addr_b] : ~rf[addr_b];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_bytes(input int lat, input bit rdwr, input int h);
        int last;
        if (!rdwr || h < lat + 2) return 0;
        last = (h < lat + 5) ? h : lat + 5;
        return last - (lat + 2) + 1;
    endfunction

    task automatic check_reset(input string tag);
        cmp({tag, " t_a"}, 32'(ad_t_a), 32'h1);
        cmp({tag, " t_b"}, 32'(ad_t_b), 32'h1);
        cmp({tag, " o_a"}, 32'(ad_o_a), 32'h0);
        cmp({tag, " o_b"}, 32'(ad_o_b), 32'h0);
        cmp({tag, " wr_a"}, 32'(wr_a), 32'h0);
        cmp({tag, " wr_b"}, 32'(wr_b), 32'h0);
        cmp({tag, " rd_a"}, 32'(rd_a), 32'h0);
        cmp({tag, " rd_b"}, 32'(rd_b), 32'h0);
        cmp({tag, " addr_a"}, 32'(addr_a), 32'h0);
        cmp({tag, " addr_b"}, 32'(addr_b), 32'h0);
        cmp({tag, " dat_a"}, dat_o_a, 32'h0);
        cmp({tag, " dat_b"}, dat_o_b, 32'h0);
    endtask

    // r is the cycle offset from N (the cycle in which the address byte is seen registered).
    task automatic check_cycle(input int d, input int lat, input bit rdwr, input logic [6:0] addr,
                               input logic [31:0] data, input int h, input int r,
                               input logic wr, input logic rd, input logic t, input logic [7:0] o,
                               input logic [6:0] ra, input logic [31:0] dato);
        bit e_wr, e_rd, e_t0;
        logic [31:0] e_o;
        e_wr = !rdwr && h >= 5 && r == 5;
        e_rd = rdwr && r == 1;
        e_t0 = rdwr && h >= lat + 2 && r >= lat + 2 && r <= lat + 5 && r <= h;
        cmp($sformatf("wr dut%0d r%0d", d, r), 32'(wr), 32'(e_wr));
        cmp($sformatf("rd dut%0d r%0d", d, r), 32'(rd), 32'(e_rd));
        cmp($sformatf("t dut%0d r%0d", d, r), 32'(t), 32'(!e_t0));
        if (e_t0) begin
            e_o = (data >> (8 * (r - lat - 2))) & 32'hFF;
            cmp($sformatf("ad_o dut%0d r%0d", d, r), 32'(o), e_o);
        end
        if (r >= 1) cmp($sformatf("addr dut%0d r%0d", d, r), 32'(ra), 32'(addr));
        if (e_wr) cmp($sformatf("dat_o dut%0d", d), dato, data);
        if (wr === 1'b1) wr_cnt[d]++;
        if (t === 1'b0) byte_cnt[d]++;
    endtask

    // Called at a negedge with both targets idle; SEL is held for h pin cycles.
    task automatic run_txn(input bit rdwr, input logic [6:0] addr, input logic [31:0] data, input int h);
        logic [31:0] w;
        w = data;
        if (rdwr) rf[addr] = data;
        wr_cnt   = '{0, 0};
        byte_cnt = '{0, 0};
        for (int k = 0; k < h + 20; k++) begin
            sel = (k < h);
            if (k == 0) ad = {rdwr, addr};
            else if (!rdwr && k <= 4) begin
                ad = w[7:0];
                w  = w >> 8;
            end else ad = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_cycle(0, LAT_A, rdwr, addr, data, h, k, wr_a, rd_a, ad_t_a, ad_o_a, addr_a, dat_o_a);
            check_cycle(1, LAT_B, rdwr, addr, data, h, k, wr_b, rd_b, ad_t_b, ad_o_b, addr_b, dat_o_b);
        end
    endtask

    task automatic check_counts(input string tag, input int e_wr, input int e_ba, input int e_bb);
        cmp({tag, " wr_cnt_a"}, 32'(wr_cnt[0]), 32'(e_wr));
        cmp({tag, " wr_cnt_b"}, 32'(wr_cnt[1]), 32'(e_wr));
        cmp({tag, " bytes_a"}, 32'(byte_cnt[0]), 32'(e_ba));
        cmp({tag, " bytes_b"}, 32'(byte_cnt[1]), 32'(e_bb));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        bit   rw;
        int   h;
        logic [6:0]  a;
        logic [31:0] dv;

        vecs[0] = '{1'b0, 7'h15, 32'h12345678, 6, 1, 0, 0};
        vecs[1] = '{1'b1, 7'h03, 32'hDEADBEEF, 11, 0, 4, 4};
        vecs[2] = '{1'b0, 7'h20, 32'hA5A5A5A5, 3, 0, 0, 0};
        vecs[3] = '{1'b0, 7'h01, 32'hCAFEF00D, 5, 1, 0, 0};
        vecs[4] = '{1'b1, 7'h2A, 32'h0BADF00D, 5, 0, 2, 0};
        vecs[5] = '{1'b0, 7'h44, 32'h89ABCDEF, 25, 1, 0, 0};
        vecs[6] = '{1'b1, 7'h7F, 32'h13579BDF, 7, 0, 4, 1};

        for (int i = 0; i < 128; i++) rf[i] = $urandom;

        #3 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("idle");

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rdwr, vecs[i].addr, vecs[i].data, vecs[i].hold);
            check_counts($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_bytes_a, vecs[i].exp_bytes_b);
        end

        // Reset asserted between edges while both targets wait on read data.
        rf[7'h33] = $urandom;
        sel = 1'b1;
        ad  = 8'hB3;
        @(posedge clk);
        @(negedge clk);
        ad = 8'($urandom);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 nrst = 1'b0;
        #1 check_reset("mid");
        sel = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_reset("post");
        run_txn(1'b1, 7'h7F, 32'h2468ACE1, 11);
        check_counts("after_rst", 0, 4, 4);

        for (int i = 0; i < 24; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            dv = $urandom;
            h  = $urandom_range(1, 14);
            run_txn(rw, a, dv, h);
            check_counts($sformatf("rnd%0d", i), (!rw && h >= 5) ? 1 : 0,
                         exp_bytes(LAT_A, rw, h), exp_bytes(LAT_B, rw, h));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
